// File: rtl/mem_bank_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_pkg: shared types and defaults for mem_bank_array.  Rev 1.0        |
// +-------------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [0:0] {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  localparam int DEF_NUM_BANK   = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 256;

endpackage
`default_nettype wire

// File: rtl/mem_bank_array_bank.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_bank: one guarded simple-dual-port RAM bank (opt. MEM_BANK_BYPASS_EN)|
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module mem_bank
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  rd_in_range;
  logic                  wr_in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_stage;

  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef MEM_BANK_BYPASS_EN
  logic collide;
  assign collide = wr_en && wr_in_range && (wr_addr == rd_addr);

  always_comb begin
    rd_word = '0;
    if (collide) begin
      rd_word = wr_data;
    end else if (rd_in_range) begin
      rd_word = mem[rd_addr];
    end
  end
`else
  // Collisions naturally return the pre-write contents here.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_stage <= '0;
    end else if (rd_en) begin
      rd_stage <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_out_reg
    logic                  stage_vld;
    logic [DATA_WIDTH-1:0] out_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        stage_vld <= 1'b0;
        out_q     <= '0;
      end else begin
        stage_vld <= rd_en;
        if (stage_vld) begin
          out_q <= rd_stage;
        end
      end
    end

    assign rd_data = out_q;
  end else begin : g_no_out_reg
    assign rd_data = rd_stage;
  end

endmodule
`default_nettype wire

// File: rtl/mem_bank_array.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_bank_array: multi-bank buffer with clear engine (opt. MEM_BANK_BYPASS_EN)|
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module mem_bank_array
  import mem_pkg::*;
#(
  parameter int NUM_BANK   = DEF_NUM_BANK,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_start,
  output logic                  clr_busy,
  input  logic [NUM_BANK-1:0]   rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr [NUM_BANK],
  output logic [NUM_BANK-1:0]   rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data [NUM_BANK],
  input  logic [NUM_BANK-1:0]   wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr [NUM_BANK],
  input  logic [DATA_WIDTH-1:0] wr_data [NUM_BANK]
);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("mem_bank_array: RD_LATENCY must be 1 or 2");
  end
  if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_addr_width
    $error("mem_bank_array: ADDR_WIDTH is derived from DEPTH");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_t            state;
  clr_state_t            state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] clr_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLR_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLR_IDLE: begin
        if (clr_start) begin
          state_nxt   = CLR_RUN;
          clr_cnt_nxt = '0;
        end
      end
      CLR_RUN: begin
        if (clr_cnt == LAST_ADDR) begin
          state_nxt = CLR_IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
        end
      end
      default: state_nxt = CLR_IDLE;
    endcase
  end

  assign clr_busy = (state == CLR_RUN);

  // While clearing, the engine owns every write port and reads are refused.
  logic [NUM_BANK-1:0] rd_accept;
  assign rd_accept = clr_busy ? '0 : rd_en;

  logic [NUM_BANK-1:0] vld_pipe [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_accept;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign rd_valid = vld_pipe[RD_LATENCY-1];

  for (genvar g = 0; g < NUM_BANK; g++) begin : g_bank
    logic                  bank_wr_en;
    logic [ADDR_WIDTH-1:0] bank_wr_addr;
    logic [DATA_WIDTH-1:0] bank_wr_data;

    assign bank_wr_en   = clr_busy ? 1'b1    : wr_en[g];
    assign bank_wr_addr = clr_busy ? clr_cnt : wr_addr[g];
    assign bank_wr_data = clr_busy ? '0      : wr_data[g];

    mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RD_LATENCY (RD_LATENCY)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (rd_accept[g]),
      .rd_addr (rd_addr[g]),
      .wr_en   (bank_wr_en),
      .wr_addr (bank_wr_addr),
      .wr_data (bank_wr_data),
      .rd_data (rd_data[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_array.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_mem_bank_array: directed bench, 256x16-bank lat1 and 200x4-bank lat2 |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_bank_array;

`ifdef MEM_BANK_BYPASS_EN
  localparam logic [15:0] EXP_COLL = 16'h2222;
`else
  localparam logic [15:0] EXP_COLL = 16'h1111;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_clr_start, a_clr_busy;
  logic [15:0] a_rd_en, a_rd_valid, a_wr_en;
  logic [7:0]  a_rd_addr [16];
  logic [7:0]  a_wr_addr [16];
  logic [15:0] a_rd_data [16];
  logic [15:0] a_wr_data [16];

  logic        b_clr_start, b_clr_busy;
  logic [3:0]  b_rd_en, b_rd_valid, b_wr_en;
  logic [7:0]  b_rd_addr [4];
  logic [7:0]  b_wr_addr [4];
  logic [15:0] b_rd_data [4];
  logic [15:0] b_wr_data [4];

  int checks = 0;
  int failures = 0;
  int busy_cycles;
  logic [15:0] acc;

  mem_bank_array #(
    .NUM_BANK(16), .DATA_WIDTH(16), .DEPTH(256), .RD_LATENCY(1)
  ) dut_a (
    .clk(clk), .rst(rst), .clr_start(a_clr_start), .clr_busy(a_clr_busy),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
  );

  mem_bank_array #(
    .NUM_BANK(4), .DATA_WIDTH(16), .DEPTH(200), .RD_LATENCY(2)
  ) dut_b (
    .clk(clk), .rst(rst), .clr_start(b_clr_start), .clr_busy(b_clr_busy),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_clr_start = 1'b0;
    a_rd_en     = '0;
    a_wr_en     = '0;
    b_clr_start = 1'b0;
    b_rd_en     = '0;
    b_wr_en     = '0;
  endtask

  function automatic logic [15:0] pat(input int b, input int a);
    return 16'hA000 | 16'(b << 8) | 16'(a);
  endfunction

  // Counts observed busy cycles; optionally pokes external traffic mid-clear.
  task automatic run_clear(input bit poke, output int n);
    n = 0;
    while (a_clr_busy === 1'b1 && n < 300) begin
      n++;
      if (poke && n == 50) begin
        a_wr_en[4]   = 1'b1;
        a_wr_addr[4] = 8'h00;
        a_wr_data[4] = 16'h7777;
        a_rd_en      = '1;
      end
      if (poke && n == 100) a_clr_start = 1'b1;
      tick();
      idle();
      if (poke && n == 50) chk("busy_no_rd_valid", a_rd_valid, 16'h0000);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    foreach (a_rd_addr[i]) begin
      a_rd_addr[i] = '0; a_wr_addr[i] = '0; a_wr_data[i] = '0;
    end
    foreach (b_rd_addr[i]) begin
      b_rd_addr[i] = '0; b_wr_addr[i] = '0; b_wr_data[i] = '0;
    end
    repeat (3) tick();
    rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_a_valid", a_rd_valid, 16'h0000);
      chk("rst_a_busy", a_clr_busy, 1'b0);
      chk("rst_a_data3", a_rd_data[3], 16'h0000);
      chk("rst_b_valid", b_rd_valid, 4'h0);
      chk("rst_b_data0", b_rd_data[0], 16'h0000);
    end

    // Write then read bank 3 address 0x10 on both latencies.
    a_wr_en[3] = 1'b1; a_wr_addr[3] = 8'h10; a_wr_data[3] = 16'hBEEF;
    b_wr_en[3] = 1'b1; b_wr_addr[3] = 8'h10; b_wr_data[3] = 16'hBEEF;
    tick(); idle();
    a_rd_en[3] = 1'b1; a_rd_addr[3] = 8'h10;
    b_rd_en[3] = 1'b1; b_rd_addr[3] = 8'h10;
    tick(); idle();
    chk("l1_valid", a_rd_valid, 16'h0008);
    chk("l1_data", a_rd_data[3], 16'hBEEF);
    chk("l2_valid_early", b_rd_valid, 4'h0);
    tick();
    chk("l1_valid_drop", a_rd_valid, 16'h0000);
    chk("l1_data_hold", a_rd_data[3], 16'hBEEF);
    chk("l2_valid", b_rd_valid, 4'h8);
    chk("l2_data", b_rd_data[3], 16'hBEEF);
    tick();
    chk("l2_valid_drop", b_rd_valid, 4'h0);
    chk("l2_data_hold", b_rd_data[3], 16'hBEEF);

    // Same-cycle collision on bank 0 address 5.
    a_wr_en[0] = 1'b1; a_wr_addr[0] = 8'd5; a_wr_data[0] = 16'h1111;
    tick();
    a_wr_data[0] = 16'h2222; a_rd_en[0] = 1'b1; a_rd_addr[0] = 8'd5;
    tick(); idle();
    chk("collision", a_rd_data[0], EXP_COLL);
    a_rd_en[0] = 1'b1;
    tick(); idle();
    chk("after_collision", a_rd_data[0], 16'h2222);

    // DEPTH=200 guard: 210 dropped, 199 normal; back-to-back pipelined reads.
    b_wr_en[1] = 1'b1; b_wr_addr[1] = 8'd210; b_wr_data[1] = 16'hABCD;
    tick();
    b_wr_addr[1] = 8'd199; b_wr_data[1] = 16'h1234;
    tick(); idle();
    b_rd_en[1] = 1'b1; b_rd_addr[1] = 8'd199;
    tick();
    b_rd_addr[1] = 8'd210;
    tick(); idle();
    chk("b199_valid", b_rd_valid, 4'h2);
    chk("b199_data", b_rd_data[1], 16'h1234);
    tick();
    chk("b210_valid", b_rd_valid, 4'h2);
    chk("b210_data", b_rd_data[1], 16'h0000);

    // Fill every bank of A with a nonzero pattern.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        a_wr_en[b] = 1'b1; a_wr_addr[b] = 8'(a); a_wr_data[b] = pat(b, a);
      end
      tick();
    end
    idle();
    a_rd_en = '1;
    foreach (a_rd_addr[i]) a_rd_addr[i] = 8'h77;
    tick(); idle();
    chk("fill_b7", a_rd_data[7], pat(7, 8'h77));
    chk("fill_b15", a_rd_data[15], pat(15, 8'h77));

    // Clear, with a read already in flight when it starts.
    a_clr_start = 1'b1;
    a_rd_en[2] = 1'b1; a_rd_addr[2] = 8'h33;
    tick(); idle();
    chk("clr_busy_rise", a_clr_busy, 1'b1);
    chk("inflight_valid", a_rd_valid, 16'h0004);
    chk("inflight_data", a_rd_data[2], pat(2, 8'h33));
    run_clear(1'b1, busy_cycles);
    chk("clr_busy_len", busy_cycles, 256);

    for (int a = 0; a < 256; a++) begin
      a_rd_en = '1;
      foreach (a_rd_addr[i]) a_rd_addr[i] = 8'(a);
      tick();
      acc = '0;
      for (int b = 0; b < 16; b++) acc = acc | a_rd_data[b];
      chk("sweep_valid", a_rd_valid, 16'hFFFF);
      chk("sweep_zero", acc, 16'h0000);
    end
    idle();

    // Reset at clear count 100, then a fresh clear starts from address 0.
    a_clr_start = 1'b1;
    tick(); idle();
    repeat (100) tick();
    chk("rc_busy_before", a_clr_busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rc_busy_after", a_clr_busy, 1'b0);
    a_wr_en[0] = 1'b1; a_wr_addr[0] = 8'h00; a_wr_data[0] = 16'h5555;
    tick(); idle();
    a_clr_start = 1'b1;
    tick(); idle();
    run_clear(1'b0, busy_cycles);
    chk("rc_busy_len", busy_cycles, 256);
    a_rd_en[0] = 1'b1; a_rd_addr[0] = 8'h00;
    tick(); idle();
    chk("rc_addr0_valid", a_rd_valid, 16'h0001);
    chk("rc_addr0_zero", a_rd_data[0], 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
